// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: ALU op codes, opcode/funct values,
// datapath select codes, FSM states and the ALU-decode state classes.
package mc_ctrl_pkg;

  localparam logic [4:0] ALUOP_NOP  = 5'd0;
  localparam logic [4:0] ALUOP_ADDU = 5'd1;
  localparam logic [4:0] ALUOP_ADD  = 5'd2;
  localparam logic [4:0] ALUOP_SUBU = 5'd3;
  localparam logic [4:0] ALUOP_SUB  = 5'd4;
  localparam logic [4:0] ALUOP_AND  = 5'd5;
  localparam logic [4:0] ALUOP_OR   = 5'd6;
  localparam logic [4:0] ALUOP_XOR  = 5'd7;
  localparam logic [4:0] ALUOP_NOR  = 5'd8;
  localparam logic [4:0] ALUOP_SLT  = 5'd9;
  localparam logic [4:0] ALUOP_SLTU = 5'd10;
  localparam logic [4:0] ALUOP_SLL  = 5'd11;
  localparam logic [4:0] ALUOP_SRL  = 5'd12;
  localparam logic [4:0] ALUOP_SRA  = 5'd13;
  localparam logic [4:0] ALUOP_SLLV = 5'd14;
  localparam logic [4:0] ALUOP_SRLV = 5'd15;
  localparam logic [4:0] ALUOP_SRAV = 5'd16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_RS = 2'b01, SRCA_RT = 2'b10;
  localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BOFS = 2'b11;
  localparam logic [1:0] EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_RS = 2'b11;
  localparam logic [1:0] REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXE_R, S_WB_R, S_EXE_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  typedef enum logic [2:0] {
    CLS_IDLE, CLS_FETCH, CLS_DECODE, CLS_EXE_R, CLS_EXE_I, CLS_ADDR, CLS_BRANCH
  } alu_cls_t;

  // NOP doubles as "unsupported funct"; every supported R-type ALU funct maps elsewhere.
  function automatic logic [4:0] r_aluop(input logic [5:0] f);
    logic [4:0] a;
    case (f)
      F_ADD:   a = ALUOP_ADD;
      F_ADDU:  a = ALUOP_ADDU;
      F_SUB:   a = ALUOP_SUB;
      F_SUBU:  a = ALUOP_SUBU;
      F_AND:   a = ALUOP_AND;
      F_OR:    a = ALUOP_OR;
      F_XOR:   a = ALUOP_XOR;
      F_NOR:   a = ALUOP_NOR;
      F_SLT:   a = ALUOP_SLT;
      F_SLTU:  a = ALUOP_SLTU;
      F_SLL:   a = ALUOP_SLL;
      F_SRL:   a = ALUOP_SRL;
      F_SRA:   a = ALUOP_SRA;
      F_SLLV:  a = ALUOP_SLLV;
      F_SRLV:  a = ALUOP_SRLV;
      F_SRAV:  a = ALUOP_SRAV;
      default: a = ALUOP_NOP;
    endcase
    return a;
  endfunction

  function automatic logic r_legal(input logic [5:0] f);
    return r_aluop(f) != ALUOP_NOP;
  endfunction

  function automatic logic is_shamt_shift(input logic [5:0] f);
    return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle; master is the control FSM, slave the datapath.
// mem_ready exists only when MC_MEM_READY_EN is defined.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
`ifdef MC_MEM_READY_EN
  logic       mem_ready;
`endif
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] EXTOp;
  logic [1:0] PCSource;
  logic [4:0] ALUOp;
  logic       Illegal;

  modport master (
`ifdef MC_MEM_READY_EN
    input  mem_ready,
`endif
    input  Op, Funct, Zero,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, Illegal
  );

  modport slave (
`ifdef MC_MEM_READY_EN
    output mem_ready,
`endif
    output Op, Funct, Zero,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, Illegal
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU op / immediate-extension decode from {state class, Op, Funct}.
// Combinational, zero latency; no backpressure.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [4:0] aluop,
  output logic [1:0] extop
);

  always_comb begin
    aluop = ALUOP_NOP;
    extop = EXT_ZERO;
    case (cls)
      CLS_FETCH: aluop = ALUOP_ADDU;
      CLS_DECODE, CLS_ADDR: begin
        aluop = ALUOP_ADDU;
        extop = EXT_SIGN;
      end
      CLS_BRANCH: aluop = ALUOP_SUBU;
      CLS_EXE_R: begin
        aluop = r_aluop(funct);
        // shamt reaches the ALU through B[10:6] of the sign-extended immediate
        if (is_shamt_shift(funct)) extop = EXT_SIGN;
      end
      CLS_EXE_I: begin
        case (op)
          OP_ADDI:  begin aluop = ALUOP_ADD;  extop = EXT_SIGN; end
          OP_ADDIU: begin aluop = ALUOP_ADDU; extop = EXT_SIGN; end
          OP_SLTI:  begin aluop = ALUOP_SLT;  extop = EXT_SIGN; end
          OP_SLTIU: begin aluop = ALUOP_SLTU; extop = EXT_SIGN; end
          OP_ANDI:  begin aluop = ALUOP_AND;  extop = EXT_ZERO; end
          OP_ORI:   begin aluop = ALUOP_OR;   extop = EXT_ZERO; end
          OP_XORI:  begin aluop = ALUOP_XOR;  extop = EXT_ZERO; end
          OP_LUI:   begin aluop = ALUOP_ADDU; extop = EXT_LUI;  end
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM (fetch/decode/execute/memory/writeback); optional MC_MEM_READY_EN.
// Latency: branch/jumps 3, R/I/sw 4, lw 5 cycles; illegal ops return to fetch after decode.
// Backpressure: with MC_MEM_READY_EN, memory states hold until mem_ready; otherwise none.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  state_t     state;
  state_t     nxt;
  alu_cls_t   cls;
  logic       ready;
  logic [4:0] dec_aluop;
  logic [1:0] dec_extop;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write, illegal;
  logic [1:0] reg_dst, mem_to_reg, src_a, src_b, pc_source;

`ifdef MC_MEM_READY_EN
  assign ready = bus.mem_ready;
`else
  assign ready = 1'b1;
`endif

  mc_alu_dec u_alu_dec (
    .cls   (cls),
    .op    (bus.Op),
    .funct (bus.Funct),
    .aluop (dec_aluop),
    .extop (dec_extop)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  // Outputs are decoded from the current state rather than registered: reset must kill
  // write enables in the same cycle, and the branch PCWrite needs this cycle's Zero.
  always_comb begin
    nxt        = S_FETCH;
    cls        = CLS_IDLE;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALU;
    src_a      = SRCA_PC;
    src_b      = SRCB_RT;
    pc_source  = PCSRC_ALU;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          cls       = CLS_FETCH;
          mem_read  = 1'b1;
          src_b     = SRCB_FOUR;
          ir_write  = ready;
          pc_write  = ready;
          nxt       = ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          cls   = CLS_DECODE;
          src_b = SRCB_BOFS;
          case (bus.Op)
            OP_RTYPE: begin
              if (bus.Funct == F_JR)     nxt = S_JR;
              else if (r_legal(bus.Funct)) nxt = S_EXE_R;
              else                         illegal = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: nxt = S_EXE_I;
            OP_LW, OP_SW:   nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE: nxt = S_BRANCH;
            OP_J:           nxt = S_JUMP;
            OP_JAL:         nxt = S_JAL;
            default:        illegal = 1'b1;
          endcase
        end
        S_EXE_R: begin
          cls = CLS_EXE_R;
          if (is_shamt_shift(bus.Funct)) begin
            src_a = SRCA_RT;
            src_b = SRCB_IMM;
          end else begin
            src_a = SRCA_RS;
            src_b = SRCB_RT;
          end
          nxt = S_WB_R;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = REGDST_RD;
        end
        S_EXE_I: begin
          cls   = CLS_EXE_I;
          src_a = SRCA_RS;
          src_b = SRCB_IMM;
          nxt   = S_WB_I;
        end
        S_WB_I: reg_write = 1'b1;
        S_MEM_ADDR: begin
          cls   = CLS_ADDR;
          src_a = SRCA_RS;
          src_b = SRCB_IMM;
          nxt   = (bus.Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          nxt      = ready ? S_WB_MEM : S_MEM_RD;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          nxt       = ready ? S_FETCH : S_MEM_WR;
        end
        S_BRANCH: begin
          cls       = CLS_BRANCH;
          src_a     = SRCA_RS;
          pc_source = PCSRC_ALUOUT;
          pc_write  = (bus.Op == OP_BEQ) ? bus.Zero : ~bus.Zero;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = M2R_PC;
        end
        S_JR: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_RS;
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite  = pc_write;
  assign bus.IorD     = iord;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.IRWrite  = ir_write;
  assign bus.RegWrite = reg_write;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.ALUSrcA  = src_a;
  assign bus.ALUSrcB  = src_b;
  assign bus.EXTOp    = dec_extop;
  assign bus.PCSource = pc_source;
  assign bus.ALUOp    = dec_aluop;
  assign bus.Illegal  = illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised instruction stream against a table-driven model of the control sequence,
// plus directed scenarios with literal expectations; honours MC_MEM_READY_EN.
module tb_mc_ctrl;

  localparam logic [4:0] A_NOP = 5'd0, A_ADDU = 5'd1, A_ADD = 5'd2, A_SUBU = 5'd3, A_SUB = 5'd4;
  localparam logic [4:0] A_AND = 5'd5, A_OR = 5'd6, A_XOR = 5'd7, A_NOR = 5'd8, A_SLT = 5'd9;
  localparam logic [4:0] A_SLTU = 5'd10, A_SLL = 5'd11, A_SRL = 5'd12, A_SRA = 5'd13;
  localparam logic [4:0] A_SLLV = 5'd14, A_SRLV = 5'd15, A_SRAV = 5'd16;

  typedef enum int {K_R, K_SHIFT, K_JR, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;
  typedef enum int {P_F, P_D, P_XR, P_WBR, P_XI, P_WBI, P_ADDR, P_LOAD, P_WBL, P_STORE,
                    P_BR, P_JUMP, P_JAL, P_JR} step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    kind_t      kind;
    logic [4:0] aop;
    logic [1:0] ext;
  } ins_t;

  typedef struct packed {
    logic       pcw, iord, mrd, mwr, irw, rgw;
    logic [1:0] rdst, m2r, sa, sb, ext, pcs;
    logic [4:0] aop;
    logic       ill;
  } cv_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();
  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  ins_t  tbl[$];
  step_t pl[$];
  cv_t   hist[$];
  int    n_pass = 0;
  int    n_total = 0;

  function automatic void add(input logic [5:0] op, input logic [5:0] f, input kind_t k,
                              input logic [4:0] a, input logic [1:0] e);
    ins_t t;
    t.op = op; t.funct = f; t.kind = k; t.aop = a; t.ext = e;
    tbl.push_back(t);
  endfunction

  function automatic ins_t classify(input logic [5:0] op, input logic [5:0] f);
    ins_t t;
    foreach (tbl[i])
      if (tbl[i].op == op && (op != 6'h00 || tbl[i].funct == f)) begin
        t = tbl[i];
        t.funct = f;
        return t;
      end
    t.op = op; t.funct = f; t.kind = K_ILL; t.aop = A_NOP; t.ext = 2'b00;
    return t;
  endfunction

  function automatic void build_plan(input ins_t in);
    pl = {};
    pl.push_back(P_F);
    pl.push_back(P_D);
    case (in.kind)
      K_R, K_SHIFT: begin pl.push_back(P_XR); pl.push_back(P_WBR); end
      K_I:          begin pl.push_back(P_XI); pl.push_back(P_WBI); end
      K_LW:         begin pl.push_back(P_ADDR); pl.push_back(P_LOAD); pl.push_back(P_WBL); end
      K_SW:         begin pl.push_back(P_ADDR); pl.push_back(P_STORE); end
      K_BEQ, K_BNE: pl.push_back(P_BR);
      K_J:          pl.push_back(P_JUMP);
      K_JAL:        pl.push_back(P_JAL);
      K_JR:         pl.push_back(P_JR);
      default:      ;
    endcase
  endfunction

  // What the datapath must see during one micro-step of an instruction.
  function automatic cv_t expect_step(input step_t s, input ins_t in, input logic z, input logic rdy);
    cv_t v = '0;
    case (s)
      P_F:     begin v.mrd = 1; v.sb = 2'b01; v.aop = A_ADDU; v.irw = rdy; v.pcw = rdy; end
      P_D:     begin v.sb = 2'b11; v.ext = 2'b01; v.aop = A_ADDU; v.ill = (in.kind == K_ILL); end
      P_XR: begin
        v.aop = in.aop;
        if (in.kind == K_SHIFT) begin v.sa = 2'b10; v.sb = 2'b10; v.ext = 2'b01; end
        else begin v.sa = 2'b01; v.sb = 2'b00; end
      end
      P_WBR:   begin v.rgw = 1; v.rdst = 2'b01; end
      P_XI:    begin v.sa = 2'b01; v.sb = 2'b10; v.ext = in.ext; v.aop = in.aop; end
      P_WBI:   v.rgw = 1;
      P_ADDR:  begin v.sa = 2'b01; v.sb = 2'b10; v.ext = 2'b01; v.aop = A_ADDU; end
      P_LOAD:  begin v.mrd = 1; v.iord = 1; end
      P_WBL:   begin v.rgw = 1; v.m2r = 2'b01; end
      P_STORE: begin v.mwr = 1; v.iord = 1; end
      P_BR:    begin v.sa = 2'b01; v.aop = A_SUBU; v.pcs = 2'b01; v.pcw = (in.kind == K_BEQ) ? z : ~z; end
      P_JUMP:  begin v.pcw = 1; v.pcs = 2'b10; end
      P_JAL:   begin v.pcw = 1; v.pcs = 2'b10; v.rgw = 1; v.rdst = 2'b10; v.m2r = 2'b10; end
      P_JR:    begin v.pcw = 1; v.pcs = 2'b11; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic tick(input cv_t e, input logic r, input logic rdy, input logic z, input string tag);
    cv_t act;
    rst = r;
    bus.Zero = z;
`ifdef MC_MEM_READY_EN
    bus.mem_ready = rdy;
`endif
    @(negedge clk);
    act = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite,
           bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.EXTOp, bus.PCSource,
           bus.ALUOp, bus.Illegal};
    n_total++;
    if (act === e) n_pass++;
    else $display("FAIL %s rdy=%0b: got %h, expected %h", tag, rdy, act, e);
    hist.push_back(act);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // rst_at: step index that gets a reset cycle (-1 none); waits: memory stall cycles
  // per memory step (-1 random); zf: forced Zero (-1 random).
  task automatic run_instr(input ins_t in, input int rst_at, input int waits, input int zf);
    build_plan(in);
    bus.Op = in.op;
    bus.Funct = in.funct;
    foreach (pl[k]) begin
      int   nw = 0;
      logic z;
`ifdef MC_MEM_READY_EN
      if (pl[k] inside {P_F, P_LOAD, P_STORE})
        nw = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
`endif
      z = (zf < 0) ? 1'($urandom_range(0, 1)) : (zf != 0);
      if (k == rst_at) begin
        tick('0, 1'b1, 1'b1, z, $sformatf("rst op=%h step=%0d", in.op, k));
        return;
      end
      for (int w = 0; w < nw; w++)
        tick(expect_step(pl[k], in, z, 1'b0), 1'b0, 1'b0, z, $sformatf("wait op=%h step=%0d", in.op, k));
      tick(expect_step(pl[k], in, z, 1'b1), 1'b0, 1'b1, z,
           $sformatf("op=%h funct=%h step=%0d", in.op, in.funct, k));
    end
  endtask

  initial begin
    int   b;
    ins_t t;
    add(6'h00, 6'h21, K_R, A_ADDU, 0); add(6'h00, 6'h20, K_R, A_ADD, 0);
    add(6'h00, 6'h23, K_R, A_SUBU, 0); add(6'h00, 6'h22, K_R, A_SUB, 0);
    add(6'h00, 6'h24, K_R, A_AND, 0);  add(6'h00, 6'h25, K_R, A_OR, 0);
    add(6'h00, 6'h26, K_R, A_XOR, 0);  add(6'h00, 6'h27, K_R, A_NOR, 0);
    add(6'h00, 6'h2A, K_R, A_SLT, 0);  add(6'h00, 6'h2B, K_R, A_SLTU, 0);
    add(6'h00, 6'h00, K_SHIFT, A_SLL, 0); add(6'h00, 6'h02, K_SHIFT, A_SRL, 0);
    add(6'h00, 6'h03, K_SHIFT, A_SRA, 0); add(6'h00, 6'h04, K_R, A_SLLV, 0);
    add(6'h00, 6'h06, K_R, A_SRLV, 0); add(6'h00, 6'h07, K_R, A_SRAV, 0);
    add(6'h00, 6'h08, K_JR, A_NOP, 0);
    add(6'h08, 0, K_I, A_ADD, 2'b01);  add(6'h09, 0, K_I, A_ADDU, 2'b01);
    add(6'h0A, 0, K_I, A_SLT, 2'b01);  add(6'h0B, 0, K_I, A_SLTU, 2'b01);
    add(6'h0C, 0, K_I, A_AND, 2'b00);  add(6'h0D, 0, K_I, A_OR, 2'b00);
    add(6'h0E, 0, K_I, A_XOR, 2'b00);  add(6'h0F, 0, K_I, A_ADDU, 2'b10);
    add(6'h23, 0, K_LW, A_NOP, 0);     add(6'h2B, 0, K_SW, A_NOP, 0);
    add(6'h04, 0, K_BEQ, A_NOP, 0);    add(6'h05, 0, K_BNE, A_NOP, 0);
    add(6'h02, 0, K_J, A_NOP, 0);      add(6'h03, 0, K_JAL, A_NOP, 0);

    rst = 1'b1; bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0;
`ifdef MC_MEM_READY_EN
    bus.mem_ready = 1'b1;
`endif
    @(posedge clk); #1;
    tick('0, 1'b1, 1'b1, 1'b0, "reset");
    tick('0, 1'b1, 1'b1, 1'b1, "reset");

    // addu $3,$1,$2
    b = hist.size();
    run_instr(classify(6'h00, 6'h21), -1, 0, -1);
    lit("addu_exe_regwrite", int'(hist[b+2].rgw), 0);
    lit("addu_exe_aluop", int'(hist[b+2].aop), 1);
    lit("addu_wb_regwrite", int'(hist[b+3].rgw), 1);
    lit("addu_wb_regdst", int'(hist[b+3].rdst), 1);

    // lw $5,8($4)
    b = hist.size();
    run_instr(classify(6'h23, 6'h08), -1, 0, -1);
    lit("lw_memrd_iord", int'(hist[b+3].iord), 1);
    lit("lw_memrd_read", int'(hist[b+3].mrd), 1);
    lit("lw_wb_memtoreg", int'(hist[b+4].m2r), 1);
    lit("lw_wb_regdst", int'(hist[b+4].rdst), 0);

    b = hist.size();
    run_instr(classify(6'h04, 6'h00), -1, 0, 1);
    lit("beq_taken_pcwrite", int'(hist[b+2].pcw), 1);
    lit("beq_pcsource", int'(hist[b+2].pcs), 1);
    b = hist.size();
    run_instr(classify(6'h05, 6'h00), -1, 0, 1);
    lit("bne_zero_pcwrite", int'(hist[b+2].pcw), 0);

    b = hist.size();
    run_instr(classify(6'h3F, 6'h00), -1, 0, -1);
    run_instr(classify(6'h00, 6'h21), -1, 0, -1);
    lit("illegal_pulse", int'(hist[b+1].ill), 1);
    lit("illegal_no_regwrite", int'(hist[b+1].rgw), 0);
    lit("illegal_no_memwrite", int'(hist[b+1].mwr), 0);
    lit("illegal_then_fetch", int'(hist[b+2].mrd), 1);

    b = hist.size();
    run_instr(classify(6'h2B, 6'h00), 3, 0, -1);
    run_instr(classify(6'h00, 6'h21), -1, 0, -1);
    lit("rst_memwr_memwrite", int'(hist[b+3].mwr), 0);
    lit("post_rst_fetch_read", int'(hist[b+4].mrd), 1);

    // sll $2,$3,4
    b = hist.size();
    run_instr(classify(6'h00, 6'h00), -1, 0, -1);
    lit("sll_srca", int'(hist[b+2].sa), 2);
    lit("sll_srcb", int'(hist[b+2].sb), 2);
    lit("sll_aluop", int'(hist[b+2].aop), 11);

`ifdef MC_MEM_READY_EN
    b = hist.size();
    run_instr(classify(6'h00, 6'h21), -1, 3, -1);
    lit("stall_irwrite_c1", int'(hist[b].irw), 0);
    lit("stall_irwrite_c3", int'(hist[b+2].irw), 0);
    lit("stall_irwrite_c4", int'(hist[b+3].irw), 1);
    lit("stall_pcwrite_c4", int'(hist[b+3].pcw), 1);
`endif

    repeat (400) begin
      int rst_at;
      if ($urandom_range(0, 7) == 0)
        t = classify(($urandom_range(0, 1) != 0) ? 6'h00 : 6'($urandom_range(0, 63)),
                     6'($urandom_range(0, 63)));
      else
        t = tbl[$urandom_range(0, tbl.size() - 1)];
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(t, rst_at, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
